// File: rtl/mod5_pkg.sv
// rtl/mod5_pkg.sv - shared types and defaults for the mod-5 pulse generator
package mod5_pkg;

    // Burst sequencer states; encoding is fixed so it can be probed directly.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int MOD_DEFAULT = 5;
    localparam int PHASE_W     = 3;

endpackage

// File: rtl/mod_n_shadow.sv
// rtl/mod_n_shadow.sv - shadow mod-N phase tracker with sticky terminal-count check
//
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_step           : step pulse seen by the counter (advances the phase)
//   i_chk_en         : enable comparison of i_tc_in against expected terminal count
//   i_tc_in          : counter terminal-count output
//   i_clr            : accepted burst start, clears the sticky error
//   o_phase          : shadow phase, 0..MOD-1
//   o_err            : sticky mismatch flag
module mod_n_shadow
    import mod5_pkg::*;
#(
    parameter int MOD = MOD_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_step,
    input  logic               i_chk_en,
    input  logic               i_tc_in,
    input  logic               i_clr,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_err
);

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(MOD - 1);

    logic [PHASE_W-1:0] r_phase;
    logic               r_err;
    logic               w_exp;

    // The counter updates on the same edge as r_phase, so no compare delay.
    assign w_exp = (r_phase == LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_phase <= '0;
            r_err   <= 1'b0;
        end else begin
            if (i_step) begin
                r_phase <= (r_phase == LAST) ? '0 : r_phase + PHASE_W'(1);
            end
            // A mismatch takes priority over the clear from an accepted start.
            if (i_chk_en && (i_tc_in != w_exp)) begin
                r_err <= 1'b1;
            end else if (i_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_phase = r_phase;
    assign o_err   = r_err;

endmodule

// File: rtl/mod5_pulse_gen.sv
// rtl/mod5_pulse_gen.sv - programmable burst/gap step-pulse generator with shadow phase check
//
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_start          : request a burst (sampled only in IDLE)
//   i_count, i_gap   : pulse count and idle gap, latched on accepted start
//   i_abort          : end the burst after the current cycle
//   i_chk_en, i_tc_in: terminal-count check enable and counter cout
//   o_w              : step pulse to the counter
//   o_busy, o_done   : burst in progress / one-cycle completion strobe
//   o_err, o_phase   : sticky check error and shadow phase
module mod5_pulse_gen
    import mod5_pkg::*;
#(
    parameter int MOD = MOD_DEFAULT,
    parameter int CW  = 8,
    parameter int GW  = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic [CW-1:0]      i_count,
    input  logic [GW-1:0]      i_gap,
    input  logic               i_abort,
    input  logic               i_chk_en,
    input  logic               i_tc_in,
    output logic               o_w,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [PHASE_W-1:0] o_phase
);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_rem;
    logic [GW-1:0] r_glen;
    logic [GW-1:0] r_gcnt;
    logic          r_w;
    logic          r_busy;
    logic          r_done;
    logic          w_accept;

    assign w_accept = (r_state == IDLE) && i_start;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = (i_count != '0) ? PULSE : DONE;
                end
            end
            PULSE: begin
                if ((r_rem == CW'(1)) || i_abort) begin
                    w_next_state = DONE;
                end else if (r_glen == '0) begin
                    w_next_state = PULSE;
                end else begin
                    w_next_state = GAP;
                end
            end
            GAP: begin
                if (i_abort) begin
                    w_next_state = DONE;
                end else if (r_gcnt == GW'(1)) begin
                    w_next_state = PULSE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_glen  <= '0;
            r_gcnt  <= '0;
            r_w     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_w     <= (w_next_state == PULSE);
            r_busy  <= (w_next_state == PULSE) || (w_next_state == GAP);
            r_done  <= (w_next_state == DONE);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_rem  <= i_count;
                        r_glen <= i_gap;
                    end
                end
                PULSE: begin
                    r_rem <= r_rem - CW'(1);
                    if (w_next_state == GAP) begin
                        r_gcnt <= r_glen;
                    end
                end
                GAP:     r_gcnt <= r_gcnt - GW'(1);
                default: ;
            endcase
        end
    end

    mod_n_shadow #(
        .MOD(MOD)
    ) u_shadow (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_step    (r_w),
        .i_chk_en  (i_chk_en),
        .i_tc_in   (i_tc_in),
        .i_clr     (w_accept),
        .o_phase   (o_phase),
        .o_err     (o_err)
    );

    assign o_w    = r_w;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: doc/mod5_pulse_gen.md
# mod5_pulse_gen

Stimulus-side companion to the mod-5 step counter. It emits a programmed burst of single-cycle `w` step pulses with a programmable idle gap between them. It tracks the counter's expected phase in a shadow mod-`MOD` register and checks the counter's terminal-count output (`cout`, fed back as `tc_in`) every cycle. It sits between lab control logic and the counter's `w` input.

## Interface
- `MOD`, 5, counter modulus; shadow phase wraps at `MOD`-1
- `CW`, 8, width of burst count
- `GW`, 4, width of gap length
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- `start`  in  1  request a burst; sampled only in IDLE
- `count`  in  CW  number of pulses; latched when `start` is accepted
- `gap`  in  GW  idle cycles between pulses; latched when `start` is accepted
- `abort`  in  1  terminate the burst after the current cycle
- `chk_en`  in  1  enable the terminal-count check
- `tc_in`  in  1  counter `cout`
- `w`  out  1  step pulse to the counter
- `busy`  out  1  high in PULSE and GAP
- `done`  out  1  one-cycle burst-complete strobe
- `err`  out  1  sticky terminal-count mismatch flag
- `phase`  out  3  shadow counter state, 0..`MOD`-1

## Operation
- FSM states: IDLE, PULSE, GAP, DONE. Outputs are Moore: `w`=(PULSE), `busy`=(PULSE|GAP), `done`=(DONE).
- IDLE: on `start`, latch `count` into `rem` and `gap` into `glen`, and clear `err`.
  - If `count`≠0, go to PULSE.
  - If `count`=0, go to DONE and emit no pulse.
- PULSE: on the exiting edge, `rem`←`rem`-1.
  - If `rem`=1 or `abort`, go to DONE.
  - Else if `glen`=0, go to PULSE (back-to-back pulses).
  - Else load `gcnt`←`glen` and go to GAP.
- GAP: on the exiting edge, `gcnt`←`gcnt`-1.
  - If `abort`, go to DONE.
  - Else if `gcnt`=1, go to PULSE.
- DONE: go to IDLE unconditionally. A `start` in DONE is ignored.
- `start` outside IDLE is ignored; `count` and `gap` changes are ignored while busy.
- Shadow phase:
  - On every edge ending a cycle with `w`=1, `phase`←(`phase`=`MOD`-1) ? 0 : `phase`+1.
  - `phase` persists across bursts and is cleared only by reset.
- Check:
  - Every cycle with `chk_en`=1, the expected value is exp=(`phase`=`MOD`-1).
  - If `tc_in`≠exp, `err`←1 at the next edge.
  - `err` holds until the next accepted `start` or reset. A mismatch in the same cycle as the accepting `start` wins: `err` is set.
- Reset (any time, including mid-burst): state IDLE, `w`=0, `busy`=0, `done`=0, `err`=0, `phase`=0, `rem`=0, `gcnt`=0. The counter must be reset together with this block for the check to be meaningful.

## Timing
- `start` accepted at edge E0: first `w` in the cycle after E0 (latency 1).
- With N pulses and gap G:
  - pulse k (k=0..N-1) occupies cycle 1+k·(G+1) after E0;
  - `done` falls in cycle 1+(N-1)(G+1)+1;
  - IDLE is re-entered the cycle after that.
- `count`=0: `done` in cycle 1 after E0, no `w`.
- `abort` sampled high in PULSE: that pulse completes, `done` follows next cycle. `abort` in GAP: no further pulse, `done` next cycle.
- The counter updates on the same edge as `phase`, so `tc_in` and exp change in the same cycle; there is no compare delay.
- Arithmetic is unsigned. `rem` and `gcnt` never underflow, because exits occur at value 1.

## Structure
- Shared package `mod5_pkg`:
  - state encoding localparams IDLE=2'b00, PULSE=2'b01, GAP=2'b10, DONE=2'b11;
  - default `MOD`.
- Sub-module `mod_n_shadow`: phase register, wrap logic, exp compare and sticky `err`. Inputs are `clk`, `reset_n`, `step`(=`w`), `chk_en`, `tc_in` and `clr`(=accepted `start`).
- Top level holds the FSM, `rem` and `gcnt`.

## Test plan
- Reset mid-burst (`count`=10, `gap`=3, assert `reset_n`=0 at the 3rd pulse) -> all outputs 0 and `phase`=0 immediately; no further `w`.
- `count`=5, `gap`=0, real counter attached, `chk_en`=1 -> 5 consecutive `w` cycles; `phase` 0→1→2→3→4→0; `tc_in` high exactly one cycle (after the 4th pulse); `done` in cycle 6; `err`=0.
- `count`=3, `gap`=2 -> `w` in cycles 1, 4, 7; `busy` high cycles 1–7; `done` in cycle 8.
- `count`=0 -> `done` in cycle 1, no `w`, `phase` unchanged; `start` held high during `done` -> no second burst until IDLE.
- `count`=7, `gap`=1, `abort` high in the GAP after pulse 2 -> exactly 2 pulses, `done` next cycle, `phase`=2.
- `chk_en`=1, `tc_in` forced 1 while `phase`=1 -> `err`=1 next cycle and held; next accepted `start` clears it.
